// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment frame scanner: segment table,
// blank pattern, FSM state encoding and the leading-zero helper.
package seg_pkg;

    // Segment pattern with every segment dark (active-low {g,f,e,d,c,b,a}).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex glyphs, index = nibble value.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Per-slot phase: dark guard interval, then the digit is lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg_state_t;

    // A digit is a leading zero when it and every more significant digit are
    // zero. Digit 0 is always shown so a value of zero still displays "0".
    function automatic logic digit_suppressed(input logic [15:0] v, input logic [1:0] d);
        case (d)
            2'd3:    return v[15:12] == 4'h0;
            2'd2:    return v[15:8]  == 8'h00;
            2'd1:    return v[15:4]  == 12'h000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment pattern.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_frame_scanner.sv
// Four-digit multiplexed seven-segment scanner with a per-slot blanking
// interval, leading-zero suppression and frame-synchronous value updates.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | first BLANK cycles of a slot, segments forced dark
// ST_SHOW  | remainder of the slot, active digit decoded onto cathode
module seg_frame_scanner
    import seg_pkg::*;
#(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        lz_en,
    output logic [1:0]  currLED,
    output logic [6:0]  cathode,
    output logic        blank,
    output logic        pending,
    output logic        frame_done
);

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_SHOW = CW'(BLANK);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_led;
    logic [15:0]   r_active;
    logic [15:0]   r_shadow;
    logic          r_pending;
    seg_state_t    r_state;
    logic [6:0]    r_cathode;
    logic          r_blank;
    logic          r_frame_done;

    logic [CW-1:0] w_cnt_next;
    logic [1:0]    w_led_next;
    seg_state_t    w_state_next;
    logic          w_slot_end;
    logic          w_frame_end;
    logic [3:0]    w_nibble;
    logic [6:0]    w_seg;
    logic          w_blank_next;
    logic [6:0]    w_cathode_next;
    logic          w_frame_done_next;

    // Outputs are registered from next-cycle values so cathode, blank and
    // currLED all update on the same edge as the counter they belong to.
    hex_to_seg u_hex_to_seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Prescaler, slot index and FSM next state with registered-output precompute.
    always_comb begin
        w_slot_end        = 1'b0;
        w_frame_end       = 1'b0;
        w_cnt_next        = r_cnt;
        w_led_next        = r_led;
        w_state_next      = r_state;
        w_nibble          = 4'h0;
        w_blank_next      = 1'b1;
        w_cathode_next    = SEG_BLANK;
        w_frame_done_next = 1'b0;

        w_slot_end  = (r_cnt == CNT_LAST);
        w_frame_end = w_slot_end && (r_led == 2'd3);
        w_cnt_next  = w_slot_end ? '0 : r_cnt + CW'(1);
        w_led_next  = w_slot_end ? r_led + 2'd1 : r_led;

        case (r_state)
            ST_BLANK: if (w_cnt_next >= CNT_SHOW) w_state_next = ST_SHOW;
            ST_SHOW:  if (w_slot_end)             w_state_next = ST_BLANK;
            default:                              w_state_next = ST_BLANK;
        endcase

        // r_active only changes on the frame edge, which always lands in a
        // blanked slot-0 cycle, so reading it here never mixes frames.
        w_nibble     = r_active[{w_led_next, 2'b00} +: 4];
        w_blank_next = (w_state_next == ST_BLANK) ||
                       (lz_en && digit_suppressed(r_active, w_led_next));
        w_cathode_next    = w_blank_next ? SEG_BLANK : w_seg;
        w_frame_done_next = (w_cnt_next == CNT_LAST) && (w_led_next == 2'd3);
    end

    // Scan state and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_led        <= 2'd0;
            r_state      <= ST_BLANK;
            r_cathode    <= SEG_BLANK;
            r_blank      <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_led        <= w_led_next;
            r_state      <= w_state_next;
            r_cathode    <= w_cathode_next;
            r_blank      <= w_blank_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    // Shadow/active value handshake; the commit takes the pre-load shadow so
    // a load landing on the frame edge waits for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active  <= 16'h0000;
            r_shadow  <= 16'h0000;
            r_pending <= 1'b0;
        end else begin
            if (w_frame_end && r_pending) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end
            if (load) begin
                r_shadow  <= value;
                r_pending <= 1'b1;
            end
        end
    end

    assign currLED    = r_led;
    assign cathode    = r_cathode;
    assign blank      = r_blank;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule
